// File: rtl/tm1638_key_reader.sv
// tm1638_key_reader
// Reads the TM1638 key-scan matrix: frames the key-read command on CLK/STB/DIO,
// clocks in the four scan bytes, and presents the eight board buttons as a
// registered vector together with the raw 32-bit scan.
//
// Optional build macro: TM1638_KEY_EDGE_EN
//   When defined, adds output key_press[7:0], a one-cycle pulse on the done
//   cycle marking buttons that went from released to pressed.
//   When undefined, the port and its register do not exist.
module tm1638_key_reader #(
    parameter int          CLK_DIV     = 50,
    parameter int          WAIT_CYCLES = 100,
    parameter logic [7:0]  CMD_READ    = 8'h42
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        dio_in,
    output logic        tm_clk,
    output logic        tm_stb,
    output logic        dio_out,
    output logic        dio_oe,
    output logic        busy,
    output logic        done,
    output logic [7:0]  keys,
    output logic [31:0] raw
`ifdef TM1638_KEY_EDGE_EN
    ,
    output logic [7:0]  key_press
`endif
);

    // One counter serves both the SCLK half-period and the command-to-read gap,
    // so it is sized for whichever of the two is longer.
    localparam int CNT_MAX = (CLK_DIV > WAIT_CYCLES) ? CLK_DIV : WAIT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CMD,
        S_WAIT,
        S_READ,
        S_END
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic          phase;       // 0 = SCLK low half, 1 = SCLK high half
    logic          phase_d;
    logic [4:0]    bit_cnt;
    logic [4:0]    bit_d;

    logic          sample_en;   // last cycle of a READ high half
    logic          finish;      // last cycle of END: publish results

    logic          tm_clk_d;
    logic          tm_stb_d;
    logic          dio_out_d;
    logic          dio_oe_d;
    logic          busy_d;

    logic          dio_p0;
    logic          dio_p1;
    logic [31:0]   shift;

    // Button map: bytes 0..3 carry keys 0..3 on bit 0 and keys 4..7 on bit 4.
    function automatic logic [7:0] decode_keys(input logic [31:0] s);
        logic [7:0] k;
        for (int i = 0; i < 4; i++) begin
            k[i]     = s[8*i];
            k[i + 4] = s[8*i + 4];
        end
        return k;
    endfunction

    // Stage p0 -> p1: bring the asynchronous DIO pin into the clk domain.
    always_ff @(posedge clk) begin
        dio_p0 <= dio_in;
        dio_p1 <= dio_p0;
    end

    // Capture each synchronised read bit at the end of its SCLK high half.
    always_ff @(posedge clk) begin
        if (sample_en) begin
            shift[bit_cnt] <= dio_p1;
        end
    end

    // Next-state sequencing and next-value decode of the registered pin outputs.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        phase_d   = phase;
        bit_d     = bit_cnt;
        sample_en = 1'b0;
        finish    = 1'b0;

        case (state)
            S_IDLE: begin
                // A request landing on the done cycle is dropped on purpose.
                if (start && !done) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                end
            end

            S_SETUP: begin
                if (cnt == HALF_LAST) begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end

            S_CMD, S_READ: begin
                if (cnt != HALF_LAST) begin
                    cnt_d = cnt + CNT_ONE;
                end else begin
                    cnt_d = '0;
                    if (!phase) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (state == S_CMD && bit_cnt == 5'd7) begin
                            state_d = S_WAIT;
                            bit_d   = '0;
                        end else if (state == S_READ && bit_cnt == 5'd31) begin
                            state_d = S_END;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_cnt + 5'd1;
                        end
                    end
                    if (state == S_READ && phase) begin
                        sample_en = 1'b1;
                    end
                end
            end

            S_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end

            S_END: begin
                if (cnt == HALF_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    finish  = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                phase_d = 1'b0;
                bit_d   = '0;
            end
        endcase

        // Pin values are decoded from the state being entered so that the
        // registered outputs line up cycle-for-cycle with the state register.
        tm_stb_d  = !(state_d == S_SETUP || state_d == S_CMD ||
                      state_d == S_WAIT  || state_d == S_READ);
        tm_clk_d  = !((state_d == S_CMD || state_d == S_READ) && !phase_d);
        dio_oe_d  = (state_d == S_SETUP) || (state_d == S_CMD);
        dio_out_d = (state_d == S_CMD) ? CMD_READ[bit_d[2:0]] : 1'b1;
        busy_d    = (state_d != S_IDLE);
    end

    // State, counters, pin outputs and published results; reset frees the bus at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
            tm_clk  <= 1'b1;
            tm_stb  <= 1'b1;
            dio_out <= 1'b1;
            dio_oe  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            keys    <= '0;
            raw     <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            phase   <= phase_d;
            bit_cnt <= bit_d;
            tm_clk  <= tm_clk_d;
            tm_stb  <= tm_stb_d;
            dio_out <= dio_out_d;
            dio_oe  <= dio_oe_d;
            busy    <= busy_d;
            done    <= finish;
            if (finish) begin
                raw  <= shift;
                keys <= decode_keys(shift);
            end
        end
    end

`ifdef TM1638_KEY_EDGE_EN
    // Newly pressed buttons, pulsed only alongside done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_press <= '0;
        end else if (finish) begin
            key_press <= decode_keys(shift) & ~keys;
        end else begin
            key_press <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Bench for tm1638_key_reader: a TM1638 board model answers on DIO, and a
// cycle-offset waveform model predicts every registered output.
module tb_tm1638_key_reader;

    localparam int D   = 3;
    localparam int W   = 6;
    localparam int LAT = 82*D + W + 1;
    localparam logic [7:0] CMD = 8'h42;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        dio_in = 1'b1;
    logic        tm_clk, tm_stb, dio_out, dio_oe, busy, done;
    logic [7:0]  keys;
    logic [31:0] raw;
`ifdef TM1638_KEY_EDGE_EN
    logic [7:0]  key_press;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    tm1638_key_reader #(.CLK_DIV(D), .WAIT_CYCLES(W), .CMD_READ(CMD)) dut (
        .clk(clk), .rst(rst), .start(start), .dio_in(dio_in),
        .tm_clk(tm_clk), .tm_stb(tm_stb), .dio_out(dio_out), .dio_oe(dio_oe),
        .busy(busy), .done(done), .keys(keys), .raw(raw)
`ifdef TM1638_KEY_EDGE_EN
        , .key_press(key_press)
`endif
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] keys_of(input logic [31:0] r);
        logic [7:0] k;
        for (int i = 0; i < 8; i++)
            k[i] = (i < 4) ? r[8*i] : r[8*(i-4) + 4];
        return k;
    endfunction

    // ---------------- board model ----------------
    logic [31:0] board_data = '0;
    logic [7:0]  cmd_cap = '0;
    int          rise_cnt = 0;
    int          rd_idx = 0;
    bit          oe_at_rise = 1'b1;

    always @(negedge tm_stb) begin
        rise_cnt   = 0;
        rd_idx     = 0;
        oe_at_rise = 1'b1;
    end

    always @(posedge tm_clk) begin
        if (tm_stb === 1'b0) begin
            if (rise_cnt < 8) begin
                cmd_cap[rise_cnt] = dio_out;
                if (dio_oe !== 1'b1) oe_at_rise = 1'b0;
            end
            rise_cnt++;
        end
    end

    always @(negedge tm_clk) begin
        if (tm_stb === 1'b0 && rise_cnt >= 8 && rd_idx < 32) begin
            dio_in = board_data[rd_idx];
            rd_idx++;
        end
    end

    // ---------------- reference model ----------------
    int          mk = 0;
    bit          mbusy = 1'b0;
    bit          mdone = 1'b0;
    logic [31:0] snap = '0;
    logic [31:0] exp_raw = '0;
    logic [7:0]  exp_keys = '0;
    logic [7:0]  exp_kp = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mk = 0; mbusy = 1'b0; mdone = 1'b0;
            exp_raw = '0; exp_keys = '0; exp_kp = '0;
        end else begin
            exp_kp = '0;
            if (mbusy) begin
                mk++;
                if (mk == LAT) begin
                    mbusy    = 1'b0;
                    mdone    = 1'b1;
                    exp_kp   = keys_of(snap) & ~exp_keys;
                    exp_raw  = snap;
                    exp_keys = keys_of(snap);
                end
            end else begin
                if (start && !mdone) begin
                    mbusy = 1'b1;
                    mk    = 1;
                    snap  = board_data;
                end
                mdone = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic e_stb, e_clk, e_oe, e_busy, e_done, e_dout;
        bit   dchk;
        int   j;
        if (!rst && cyc > 0) begin
            e_stb = 1'b1; e_clk = 1'b1; e_oe = 1'b0;
            e_busy = mbusy; e_done = mdone; e_dout = 1'b1; dchk = 1'b0;
            if (mbusy) begin
                if (mk <= D) begin
                    e_stb = 1'b0; e_oe = 1'b1;
                end else if (mk <= 17*D) begin
                    j = mk - D - 1;
                    e_stb = 1'b0; e_oe = 1'b1;
                    e_clk = ((j % (2*D)) >= D);
                    if (!e_clk) begin
                        dchk   = 1'b1;
                        e_dout = CMD[j / (2*D)];
                    end
                end else if (mk <= 17*D + W) begin
                    e_stb = 1'b0;
                end else if (mk <= 81*D + W) begin
                    j = mk - 17*D - W - 1;
                    e_stb = 1'b0;
                    e_clk = ((j % (2*D)) >= D);
                end
            end
            chk("tm_stb", tm_stb, e_stb);
            chk("tm_clk", tm_clk, e_clk);
            chk("dio_oe", dio_oe, e_oe);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("keys", keys, exp_keys);
            chk("raw", raw, exp_raw);
            if (dchk) chk("dio_out", dio_out, e_dout);
`ifdef TM1638_KEY_EDGE_EN
            chk("key_press", key_press, exp_kp);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_done(input string name, output int at_cyc);
        bit seen = 1'b0;
        at_cyc = 0;
        for (int i = 0; i < LAT + 50 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen   = 1'b1;
                at_cyc = cyc;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_timeout got=no_done want=done cyc=%0d", name, cyc);
        end
    endtask

    task automatic scan(input logic [31:0] data, output int lat);
        int t0, td;
        board_data = data;
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        wait_done("scan", td);
        lat = td - t0;
    endtask

    initial begin
        int lat, t0, oe_fall, dcount;
        logic [31:0] d;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_stb", tm_stb, 1'b1);
        chk("rst_clk", tm_clk, 1'b1);
        chk("rst_oe", dio_oe, 1'b0);
        chk("rst_dout", dio_out, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_keys", keys, 8'h00);
        chk("rst_raw", raw, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Command framing and key decode in one scan.
        board_data = 32'h11001001;
        @(negedge clk);
        chk("pre_stb", tm_stb, 1'b1);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("stb_fall_1cyc", tm_stb, 1'b0);
        oe_fall = 0;
        for (int i = 0; i < 200 && oe_fall == 0; i++) begin
            @(negedge clk);
            if (dio_oe === 1'b0) oe_fall = cyc;
        end
        chk("oe_fall_off", oe_fall - t0, 1 + 17*D);
        chk("cmd_bits", cmd_cap, 8'h42);
        chk("cmd_oe", oe_at_rise, 1'b1);
        wait_done("decode", t0);
        chk("latency", t0 - (oe_fall - (1 + 17*D)), 253);
        chk("dec_raw", raw, 32'h11001001);
        chk("dec_keys", keys, 8'hA9);
        chk("rise_total", rise_cnt, 40);

        // All-ones then all-zeros board.
        scan(32'hFFFF_FFFF, lat);
        chk("ones_lat", lat, LAT);
        chk("ones_keys", keys, 8'hFF);
        chk("ones_raw", raw, 32'hFFFF_FFFF);
        scan(32'h0, lat);
        chk("zero_keys", keys, 8'h00);
        chk("zero_raw", raw, 32'h0);

        // Random boards with random idle gaps.
        for (int n = 0; n < 6; n++) begin
            d = $urandom;
            repeat ($urandom_range(0, 4)) @(negedge clk);
            scan(d, lat);
            chk("rnd_raw", raw, d);
            chk("rnd_keys", keys, keys_of(d));
        end

        // Starts while busy and on the done cycle are ignored; the next one is not.
        board_data = $urandom;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcount = 0;
        for (int i = 1; i <= LAT + 20 && dcount == 0; i++) begin
            @(negedge clk);
            start = (i == 10 || i == 80 || i == 200);
            if (done === 1'b1) begin
                dcount++;
                start = 1'b1;
            end
        end
        chk("one_done", dcount, 1);
        @(negedge clk);
        chk("done_1cyc", done, 1'b0);
        chk("done_cyc_start_ignored", busy, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy", busy, 1'b1);
        chk("restart_stb", tm_stb, 1'b0);
        wait_done("restart", t0);

        // Reset in the middle of READ.
        scan(32'h1111_1111, lat);
        chk("pre_rst_keys", keys, 8'hFF);
        board_data = $urandom;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (17*D + W + 20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_stb", tm_stb, 1'b1);
        chk("mid_rst_clk", tm_clk, 1'b1);
        chk("mid_rst_oe", dio_oe, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_keys", keys, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < LAT + 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        chk("no_done_after_rst", dcount, 0);

`ifdef TM1638_KEY_EDGE_EN
        scan(32'h0, lat);
        chk("edge_k0", keys, 8'h00);
        scan(32'h0001_0001, lat);
        chk("edge_k1", keys, 8'h05);
        chk("edge_kp1", key_press, 8'h05);
        @(negedge clk);
        chk("edge_kp1_off", key_press, 8'h00);
        scan(32'h0001_0101, lat);
        chk("edge_k2", keys, 8'h07);
        chk("edge_kp2", key_press, 8'h02);
        @(negedge clk);
        chk("edge_kp2_off", key_press, 8'h00);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running want=finished cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
